// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with credit-limited issue and output FIFO
// Responses pair with their PCs through an in-order address queue; redirects flush and drop stale data.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          started_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] pq_head_q, pq_tail_q;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   pcq_q       [DEPTH];

  logic [CW:0]   credit;
  logic          accept, rsp_fire, rsp_drop, push, pop;

  // started_q keeps requests quiet while reset is held and for the release cycle.
  always_comb begin
    credit         = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req_valid = started_q && (credit < CREDITS) && !redirect_valid;
    accept         = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (inflight_q != '0);
    rsp_drop       = rsp_fire && (drop_q != '0);
    push           = rsp_fire && !rsp_drop;
    pop            = inst_valid && inst_ready;
  end

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? fifo_data_q[head_q] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc_q[head_q]   : 32'd0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(rsp_fire);
    drop_d     = drop_q - CW'(rsp_drop);
    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + PW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_d     = inflight_q - CW'(rsp_fire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      started_q  <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pq_head_q  <= '0;
      pq_tail_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      started_q  <= 1'b1;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pq_head_q  <= pq_head_q + PW'(rsp_fire);
      pq_tail_q  <= pq_tail_q + PW'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo_pc_q[tail_q]   <= pcq_q[pq_head_q];
      fifo_data_q[tail_q] <= imem_rsp_data;
    end
    if (accept) pcq_q[pq_tail_q] <= fetch_pc_q;
    if (reset_n && push && !pop && !redirect_valid) assert (count_q < FULL);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle CPU decode/execute logic; replaces the direct combinational iaddr->imem->idata path.
- Issues sequential word fetches to a variable-latency instruction memory through a request/response handshake.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to the consumer with valid/ready.
- Redirects (branch, JAL, JALR) flush the buffer and discard in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries and the maximum number of requests in flight. Must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  word-aligned fetch address (fetch_pc).
- imem_rsp_valid  in  1  response data valid. Responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  returned instruction word.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  consumer takes the head this cycle.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  head instruction address.
- redirect_valid  in  1  control-flow change (one-cycle pulse or held).
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.

Behaviour:
- State:
  - fetch_pc (32 bits).
  - FIFO of {pc, data}: DEPTH entries, head/tail pointers, count.
  - inflight counter: accepted requests not yet answered.
  - drop counter: in-flight responses to discard.
  - pc_q: DEPTH-entry in-order queue of issued addresses, pushed on acceptance and popped on response.
  - Counter widths: clog2(DEPTH)+1.
- Reset (asynchronous assert, deassert is synchronous to clk):
  - fetch_pc=RESET_PC.
  - All pointers, counts, inflight and drop are 0.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-transaction discards everything. Responses arriving after reset release with inflight==0 are ignored.
- Request issue:
  - imem_req_valid = (count + inflight < DEPTH) && !redirect_valid.
  - Acceptance = imem_req_valid && imem_req_ready. On acceptance: push fetch_pc to pc_q, fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
  - imem_addr must stay stable while imem_req_valid is high and not accepted.
- Response:
  - On imem_rsp_valid with inflight>0: pop pc_q and decrement inflight.
  - If drop>0: decrement drop and discard the word.
  - Otherwise: push {popped pc, imem_rsp_data} into the FIFO.
  - Space is guaranteed by the credit rule, so FIFO overflow is impossible; assert this in simulation.
  - imem_rsp_valid with inflight==0 is ignored.
- Output:
  - inst_valid = (count != 0).
  - inst_data and inst_pc come from the head entry, registered storage (no combinational path from imem_rsp_data).
  - Pop on inst_valid && inst_ready.
  - Latency: request accepted in cycle N, response in cycle N+L, inst_valid in cycle N+L+1.
  - Push and pop in the same cycle keep count unchanged. Both are legal when full or when count==1.
- Redirect (takes priority over all other updates in that cycle):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO cleared (count=0, pointers reset).
  - A consumer handshake in the same cycle completes: the instruction is considered taken, then flushed.
  - drop = inflight remaining after this cycle's response, i.e. inflight minus (1 if imem_rsp_valid && inflight>0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. The first request to the new target goes out the next cycle.
  - Back-to-back redirects: the last one wins, and drop recomputes each cycle.
- Stall: inst_ready held low fills the FIFO. Once count + inflight == DEPTH, requests stop until a pop.
- Dropped responses still consume inflight credit until they return.

Test Plan:
- Zero-wait memory (ready=1, 1-cycle response), inst_ready=1 after reset_n rise -> one inst per cycle, inst_pc sequence 0,4,8,12.
- inst_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests accepted, inst_valid=1 with inst_pc=0. Release -> pcs 0,4,8,12,16 in order with no gaps or duplicates.
- Memory latency 3, redirect_pc=0x103 while 2 requests are in flight -> both stale responses discarded. Next inst_pc=0x100, then 0x104.
- Redirect in the same cycle as an imem response and an inst handshake -> the handshaken inst is taken, the response is dropped, FIFO is empty next cycle, the following request address is the redirect target.
- Start fetch_pc=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset_n low asynchronously mid-burst with 3 in flight -> outputs go to 0 immediately. After release, stray responses are ignored and fetch restarts at RESET_PC.
